// File: rtl/cpu_mem_loader.sv
// Host-side loader for the CPU's external IMEM/DMEM ports: streams words in,
// dumps DMEM out, and runs the CPU for a bounded number of cycles.
module cpu_mem_loader #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] din_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] dout_data,
    output logic        busy,
    output logic        err,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable
);

    localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
    localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
    localparam logic [1:0] OP_DUMP_DMEM = 2'd2;
    localparam logic [1:0] OP_RUN       = 2'd3;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [65:0] IMEM_LIMIT = 66'd1 << (IMEM_ADDR_W + 2);
    localparam logic [65:0] DMEM_LIMIT = 66'd1 << (DMEM_ADDR_W + 3);

    typedef enum logic [2:0] {
        IDLE, LOAD_I, LOAD_D, DUMP_RD, DUMP_WAIT, DUMP_OUT, RUN
    } state_t;

    state_t            state;
    logic [15:0]       count;
    logic [LAT_W-1:0]  lat_cnt;
    logic [63:0]       imem_addr;
    logic [63:0]       dmem_addr;
    logic [31:0]       imem_wdata_q;
    logic [63:0]       dmem_wdata_q;
    logic [63:0]       dout_q;
    logic              err_q;

    logic              cmd_fire;
    logic              is_imem;
    logic              aligned;
    logic [65:0]       end_excl;
    logic [65:0]       limit;
    logic              range_bad;
    logic              unused_bits;

    // Range check on the exclusive end address; 66 bits so a huge addr cannot wrap.
    always_comb begin
        cmd_fire  = cmd_valid && cmd_ready;
        is_imem   = (cmd_op == OP_LOAD_IMEM);
        aligned   = is_imem ? (cmd_addr[1:0] == 2'b00) : (cmd_addr[2:0] == 3'b000);
        end_excl  = is_imem ? ({2'b00, cmd_addr} + {48'd0, cmd_len, 2'b00})
                            : ({2'b00, cmd_addr} + {47'd0, cmd_len, 3'b000});
        limit     = is_imem ? IMEM_LIMIT : DMEM_LIMIT;
        range_bad = (cmd_op != OP_RUN) &&
                    (!aligned || ((cmd_len != 16'd0) && (end_excl > limit)));
    end

    // Enables are gated by rst so the reset cycle itself performs no access.
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign err         = err_q;
    assign din_ready   = ((state == LOAD_I) || (state == LOAD_D)) && !rst;
    assign wen_ext     = (state == LOAD_I) && din_valid && !rst;
    assign wen_ext_2   = (state == LOAD_D) && din_valid && !rst;
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = (state == DUMP_RD) && !rst;
    assign cpu_enable  = (state == RUN) && !rst;
    assign dout_valid  = (state == DUMP_OUT);
    assign dout_data   = dout_q;
    assign addr_ext    = imem_addr;
    assign addr_ext_2  = dmem_addr;
    assign wdata_ext   = wen_ext   ? din_data[31:0] : imem_wdata_q;
    assign wdata_ext_2 = wen_ext_2 ? din_data       : dmem_wdata_q;
    assign unused_bits = ^rdata_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            lat_cnt      <= '0;
            imem_addr    <= '0;
            dmem_addr    <= '0;
            imem_wdata_q <= '0;
            dmem_wdata_q <= '0;
            dout_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            count <= cmd_len;
                            // Zero-length commands finish here without touching memory.
                            if (cmd_len != 16'd0) begin
                                case (cmd_op)
                                    OP_LOAD_IMEM: begin
                                        imem_addr <= cmd_addr;
                                        state     <= LOAD_I;
                                    end
                                    OP_LOAD_DMEM: begin
                                        dmem_addr <= cmd_addr;
                                        state     <= LOAD_D;
                                    end
                                    OP_DUMP_DMEM: begin
                                        dmem_addr <= cmd_addr;
                                        state     <= DUMP_RD;
                                    end
                                    default: state <= RUN;
                                endcase
                            end
                        end
                    end
                end
                LOAD_I: begin
                    if (din_valid) begin
                        imem_wdata_q <= din_data[31:0];
                        imem_addr    <= imem_addr + 64'd4;
                        count        <= count - 16'd1;
                        if (count == 16'd1) state <= IDLE;
                    end
                end
                LOAD_D: begin
                    if (din_valid) begin
                        dmem_wdata_q <= din_data;
                        dmem_addr    <= dmem_addr + 64'd8;
                        count        <= count - 16'd1;
                        if (count == 16'd1) state <= IDLE;
                    end
                end
                DUMP_RD: begin
                    lat_cnt <= '0;
                    state   <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                        dout_q <= rdata_ext_2;
                        state  <= DUMP_OUT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                DUMP_OUT: begin
                    if (dout_ready) begin
                        dmem_addr <= dmem_addr + 64'd8;
                        count     <= count - 16'd1;
                        state     <= (count == 16'd1) ? IDLE : DUMP_RD;
                    end
                end
                RUN: begin
                    count <= count - 16'd1;
                    if (count == 16'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader with simple IMEM/DMEM responder models.
module tb_cpu_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [63:0] cmd_addr = 64'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [63:0] din_data = 64'd0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] dout_data;
    logic        busy;
    logic        err;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'd0;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'd0;
    logic        cpu_enable;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [512];
    logic [63:0] dmem [1024];
    logic [63:0] imem_log_a[$];
    logic [31:0] imem_log_d[$];
    logic [63:0] dmem_log_a[$];
    logic [63:0] exp_q[$];
    int ren_cnt = 0;
    int en_cnt = 0;
    int excl_viol = 0;

    cpu_mem_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .busy(busy), .err(err),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory responders: write on the edge, DMEM read data one cycle after ren
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    // bus monitor
    always @(negedge clk) begin
        if (wen_ext) begin
            imem_log_a.push_back(addr_ext);
            imem_log_d.push_back(wdata_ext);
        end
        if (wen_ext_2) dmem_log_a.push_back(addr_ext_2);
        if (ren_ext_2) ren_cnt++;
        if (cpu_enable) en_cnt++;
        if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext)) excl_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send_cmd(input logic [1:0] op, input logic [63:0] a, input logic [15:0] n);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = n;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] d, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        din_valid = 1'b1; din_data = d;
        while (!din_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("din_accept", {63'd0, din_ready}, 64'd1);
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] iw [4];
        logic [63:0] dw [3];
        logic [63:0] prev_data;
        logic        prev_hold;
        logic [63:0] got_word;
        int got, stab_err, n, base, busy_n;

        for (int i = 0; i < 512; i++) imem[i] = 32'd0;
        for (int i = 0; i < 1024; i++) dmem[i] = 64'd0;
        iw[0] = 32'h00500093; iw[1] = 32'h00A00113; iw[2] = 32'h002081B3; iw[3] = 32'h00000013;
        dw[0] = 64'h1111_2222_3333_4444;
        dw[1] = 64'hDEAD_BEEF_0123_4567;
        dw[2] = 64'hA5A5_5A5A_FFFF_0000;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_enables", {59'd0, wen_ext, wen_ext_2, ren_ext_2, cpu_enable, din_ready}, 64'd0);
        chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);

        // LOAD_IMEM 4 words with 2-cycle din gaps
        send_cmd(2'd0, 64'h0, 16'd4);
        chk("limem_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("limem_busy_before_last", {63'd0, busy}, 64'd1);
            push_word({32'hFFFF_FFFF, iw[i]}, 2);
        end
        chk("limem_busy_after", {63'd0, busy}, 64'd0);
        chk("limem_pulses", 64'(imem_log_a.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("limem_addr", imem_log_a[i], 64'(i * 4));
            chk("limem_wdata", {32'd0, imem_log_d[i]}, {32'd0, iw[i]});
            chk("limem_readback", {32'd0, imem[i]}, {32'd0, iw[i]});
        end

        // LOAD_DMEM then DUMP_DMEM with dout_ready toggling
        send_cmd(2'd1, 64'h10, 16'd3);
        for (int i = 0; i < 3; i++) begin
            push_word(dw[i], 0);
            exp_q.push_back(dw[i]);
        end
        wait_idle("ldmem_idle");
        chk("ldmem_pulses", 64'(dmem_log_a.size()), 64'd3);
        chk("ldmem_addr0", dmem_log_a[0], 64'h10);
        chk("ldmem_addr2", dmem_log_a[2], 64'h20);
        base = ren_cnt;
        send_cmd(2'd2, 64'h10, 16'd3);
        got = 0; stab_err = 0; prev_hold = 1'b0; prev_data = 64'd0;
        for (int c = 0; c < 200 && got < 3; c++) begin
            @(negedge clk);
            dout_ready = ~dout_ready;
            if (dout_valid) begin
                if (prev_hold && dout_data !== prev_data) stab_err++;
                if (dout_ready) begin
                    got_word = exp_q.pop_front();
                    chk("dump_word", dout_data, got_word);
                    got++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_data = dout_data;
                end
            end
        end
        @(negedge clk);
        dout_ready = 1'b0;
        wait_idle("dump_idle");
        chk("dump_count", 64'(got), 64'd3);
        chk("dump_stable", 64'(stab_err), 64'd0);
        chk("dump_reads", 64'(ren_cnt - base), 64'd3);

        // RUN 20 cycles
        base = en_cnt;
        send_cmd(2'd3, 64'h0, 16'd20);
        n = 0;
        @(negedge clk);
        while (cpu_enable && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("run_len", 64'(n), 64'd20);
        chk("run_ready_after", {63'd0, cmd_ready}, 64'd1);
        chk("run_en_total", 64'(en_cnt - base), 64'd20);
        chk("run_exclusive", 64'(excl_viol), 64'd0);
        chk("run_no_imem_wr", 64'(imem_log_a.size()), 64'd4);
        chk("run_no_dmem_wr", 64'(dmem_log_a.size()), 64'd3);

        // out-of-range IMEM load, then a legal command at the boundary clears err
        send_cmd(2'd0, 64'h7FC, 16'd2);
        chk("range_err", {63'd0, err}, 64'd1);
        chk("range_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        din_valid = 1'b1; din_data = 64'h55;
        repeat (5) @(negedge clk);
        chk("range_din_ready", {63'd0, din_ready}, 64'd0);
        din_valid = 1'b0;
        chk("range_no_wr", 64'(imem_log_a.size()), 64'd4);
        send_cmd(2'd0, 64'h7F8, 16'd2);
        chk("range_err_clear", {63'd0, err}, 64'd0);
        push_word(64'hCAFE_0001, 0);
        push_word(64'hCAFE_0002, 1);
        wait_idle("edge_idle");
        chk("edge_addr_a", imem_log_a[4], 64'h7F8);
        chk("edge_addr_b", imem_log_a[5], 64'h7FC);
        chk("edge_readback", {32'd0, imem[511]}, 64'hCAFE_0002);

        // misaligned dump, zero-length dump, zero-length run
        base = ren_cnt;
        send_cmd(2'd2, 64'h4, 16'd1);
        chk("misalign_err", {63'd0, err}, 64'd1);
        repeat (4) @(negedge clk);
        chk("misalign_no_rd", 64'(ren_cnt - base), 64'd0);
        send_cmd(2'd2, 64'h10, 16'd0);
        chk("len0_err", {63'd0, err}, 64'd0);
        busy_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy || dout_valid) busy_n++;
            @(negedge clk);
        end
        chk("len0_busy", {63'd0, busy_n <= 1}, 64'd1);
        chk("len0_no_rd", 64'(ren_cnt - base), 64'd0);
        base = en_cnt;
        send_cmd(2'd3, 64'h0, 16'd0);
        repeat (5) @(negedge clk);
        chk("run0_no_enable", 64'(en_cnt - base), 64'd0);

        // reset in the middle of a 5-word DMEM load
        send_cmd(2'd1, 64'h40, 16'd5);
        push_word(64'hAAAA_0000_0000_0001, 0);
        push_word(64'hAAAA_0000_0000_0002, 0);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b1; din_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #1;
        chk("mrst_enables", {60'd0, wen_ext, wen_ext_2, ren_ext_2, cpu_enable}, 64'd0);
        chk("mrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("mrst_din_ready", {63'd0, din_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        din_valid = 1'b0;
        chk("mrst_wr_count", 64'(dmem_log_a.size()), 64'd5);
        chk("mrst_word1", dmem[9], 64'hAAAA_0000_0000_0002);
        chk("mrst_word2_untouched", dmem[10], 64'd0);
        chk("mrst_idle", {63'd0, busy}, 64'd0);
        chk("final_exclusive", 64'(excl_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
